arm7tdmi_coherency_queue: RTL

- Multi-region I-cache coherency controller. It snoops D-side write commits and matches them against up to NUM_REGIONS programmable code regions.
- Each matching write is turned into an I-cache line-invalidate request, buffered in a deduplicating FIFO and drained one line at a time over a req/ack handshake.
- Sits between the D-cache write path and the I-cache invalidate port inside the cache subsystem. It replaces the single-region, single-outstanding coherency logic.

---
 rtl/arm7tdmi_coherency_queue.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/arm7tdmi_coherency_queue.sv
// ---------------------------------------------------------------------------
// arm7tdmi_coherency_queue
//
// Purpose:
//   I-cache coherency controller. It watches D-side write commits and checks
//   each one against up to NUM_REGIONS programmable code regions. A write
//   that hits a region becomes a line-invalidate request. Requests are held
//   in a small deduplicating FIFO and sent one line at a time to the I-cache
//   over a req/ack handshake.
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   coherency_enable   global enable for new snoop matches
//   region_en          per-region enable
//   region_base        packed region bases, region i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   region_size        packed region sizes in bytes (0 = region off)
//   snoop_valid        D-side write commit this cycle
//   snoop_addr         write byte address
//   snoop_byte_en      write byte enables
//   snoop_ready        controller can accept the write (queue not full)
//   inv_req, inv_addr  line-invalidate request and its line-aligned address
//   inv_ack            I-cache completed the current invalidate
//   queue_count        valid FIFO entries
//   invalidations      completed invalidates (saturating)
//   merged             writes absorbed by dedup (saturating)
//   busy               queue non-empty or request outstanding
// ---------------------------------------------------------------------------
module arm7tdmi_coherency_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 4,
  parameter int LINE_SIZE   = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              coherency_enable,
  input  logic [NUM_REGIONS-1:0]            region_en,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_WIDTH-1:0] region_size,
  input  logic                              snoop_valid,
  input  logic [ADDR_WIDTH-1:0]             snoop_addr,
  input  logic [3:0]                        snoop_byte_en,
  output logic                              snoop_ready,
  output logic                              inv_req,
  output logic [ADDR_WIDTH-1:0]             inv_addr,
  input  logic                              inv_ack,
  output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
  output logic [31:0]                       invalidations,
  output logic [31:0]                       merged,
  output logic                              busy
);

  localparam int LINE_BITS = $clog2(LINE_SIZE);
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  inv_req_q, inv_req_d;
  logic [ADDR_WIDTH-1:0] entries_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] entries_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [31:0]           inv_cnt_q, inv_cnt_d;
  logic [31:0]           merged_q, merged_d;

  logic [NUM_REGIONS-1:0] region_hit;
  logic [QUEUE_DEPTH-1:0] slot_match;
  logic [ADDR_WIDTH-1:0]  line_addr;
  logic                   full;
  logic                   pop;
  logic                   hit;
  logic                   dup;
  logic                   enq;
  logic                   merge;

  assign line_addr = {snoop_addr[ADDR_WIDTH-1:LINE_BITS], {LINE_BITS{1'b0}}};

  // Range compare is done one bit wider so a region ending exactly at the
  // top of the address space does not wrap to zero.
  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
    logic [ADDR_WIDTH:0] base_ext;
    logic [ADDR_WIDTH:0] size_ext;
    logic [ADDR_WIDTH:0] end_ext;
    logic [ADDR_WIDTH:0] addr_ext;

    assign base_ext = {1'b0, region_base[gi*ADDR_WIDTH +: ADDR_WIDTH]};
    assign size_ext = {1'b0, region_size[gi*ADDR_WIDTH +: ADDR_WIDTH]};
    assign end_ext  = base_ext + size_ext;
    assign addr_ext = {1'b0, snoop_addr};

    assign region_hit[gi] = region_en[gi] && (size_ext != '0) &&
                            (addr_ext >= base_ext) && (addr_ext < end_ext);
  end

  // Dedup compare against every occupied slot. The head being acked this
  // cycle is excluded: the write may land after that invalidate, so the
  // line must be invalidated again.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] offset;
    logic             occupied;

    assign offset     = PTR_W'(gi) - head_q;
    assign occupied   = ({1'b0, offset} < count_q);
    assign slot_match[gi] = occupied && !(pop && (PTR_W'(gi) == head_q)) &&
                            (entries_q[gi] == line_addr);
  end

  // snoop_ready depends only on the registered count; a same-cycle pop does
  // not open a slot for this cycle's snoop.
  assign full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign pop   = inv_ack && inv_req_q;
  assign hit   = snoop_valid && coherency_enable && (snoop_byte_en != 4'b0000) &&
                 (|region_hit);
  assign dup   = |slot_match;
  assign enq   = hit && !full && !dup;
  assign merge = hit && !full && dup;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    inv_cnt_d = inv_cnt_q;
    merged_d  = merged_q;
    state_d   = state_q;

    if (enq) begin
      entries_d[tail_q] = line_addr;
      tail_d            = tail_q + 1'b1;
    end

    if (pop) begin
      head_d = head_q + 1'b1;
      if (inv_cnt_q != 32'hFFFF_FFFF) begin
        inv_cnt_d = inv_cnt_q + 32'd1;
      end
    end

    if (merge && (merged_q != 32'hFFFF_FFFF)) begin
      merged_d = merged_q + 32'd1;
    end

    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The drain decision looks at post-edge occupancy, so a request goes out
    // on the cycle right after the entry is written and stays up across
    // back-to-back entries.
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (pop && (count_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    inv_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inv_req_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      inv_cnt_q <= '0;
      merged_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      inv_req_q <= inv_req_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      inv_cnt_q <= inv_cnt_d;
      merged_q  <= merged_d;
      entries_q <= entries_d;
    end
  end

  assign snoop_ready   = !full;
  assign inv_req       = inv_req_q;
  assign inv_addr      = inv_req_q ? entries_q[head_q] : '0;
  assign queue_count   = count_q;
  assign invalidations = inv_cnt_q;
  assign merged        = merged_q;
  assign busy          = inv_req_q || (count_q != '0);

endmodule
